freq_divider_tick: RTL

//   Parametrised clock divider / timebase. Divides clk by DIV = CLK_FREQ_HZ/OUT_FREQ_HZ.

---
 rtl/freq_divider_tick.sv | 103 ++++++++++
 1 files changed

// File: rtl/freq_divider_tick.sv
// Parametrised clock divider / timebase: square wave, one-cycle tick strobe and tick counter.
// Optional runtime-loadable divisor when FREQ_DIV_LOAD_EN is defined.
module freq_divider_tick #(
  parameter int CLK_FREQ_HZ = 100,
  parameter int OUT_FREQ_HZ = 1,
  parameter int CNT_W       = 16,
  parameter int TCNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clear,
`ifdef FREQ_DIV_LOAD_EN
  input  logic              i_div_load,
  input  logic [CNT_W-1:0]  i_div_value,
`endif
  output logic              o_out,
  output logic              o_tick,
  output logic [TCNT_W-1:0] o_tick_count,
  output logic [CNT_W-1:0]  o_phase
);

  localparam int              DIV   = CLK_FREQ_HZ / OUT_FREQ_HZ;
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);

  generate
    if ((DIV < 2) || ((longint'(1) << CNT_W) <= longint'(DIV))) begin : g_cfg_check
      $error("freq_divider_tick: DIV must be >= 2 and fit in CNT_W bits");
    end
  endgenerate

  logic [CNT_W-1:0]  r_cnt;
  logic              r_out;
  logic              r_tick;
  logic [TCNT_W-1:0] r_tick_count;

  logic [CNT_W-1:0]  w_div;
  logic [CNT_W-1:0]  w_half;
  logic [CNT_W-1:0]  w_last;
  logic [CNT_W-1:0]  w_cnt_inc;

`ifdef FREQ_DIV_LOAD_EN
  logic [CNT_W-1:0]  r_div;

  // Divisors below 2 cannot produce both a low and a high phase.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    if (v < CNT_W'(2)) begin
      return CNT_W'(2);
    end else begin
      return v;
    end
  endfunction

  assign w_div = r_div;
`else
  assign w_div = DIV_C;
`endif

  assign w_half    = w_div >> 1;
  assign w_last    = w_div - CNT_W'(1);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Phase counter, square wave, strobe and tick counter; priority rst > load > clear > en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_out        <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
`ifdef FREQ_DIV_LOAD_EN
      r_div        <= DIV_C;
    end else if (i_div_load) begin
      r_div        <= clamp_div(i_div_value);
      r_cnt        <= '0;
      r_out        <= 1'b0;
      r_tick       <= 1'b0;
`endif
    end else if (i_clear) begin
      r_cnt        <= '0;
      r_out        <= 1'b0;
      r_tick       <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == w_last) begin
        r_cnt        <= '0;
        r_out        <= 1'b0;
        r_tick       <= 1'b1;
        r_tick_count <= r_tick_count + TCNT_W'(1);
      end else begin
        r_cnt        <= w_cnt_inc;
        r_out        <= (w_cnt_inc >= w_half);
        r_tick       <= 1'b0;
      end
    end else begin
      r_tick       <= 1'b0;
    end
  end

  assign o_out        = r_out;
  assign o_tick       = r_tick;
  assign o_tick_count = r_tick_count;
  assign o_phase      = r_cnt;

endmodule
